potential_decay_array: RTL and testbench

Clocked, multi-neuron membrane-potential decay engine for the LIF accelerator. It stores one FP32 (IEEE-754 single) potential and one decay code per neuron. On each timestep `start` it sweeps every neuron, one per cycle, and streams the decayed values out. Between sweeps, the potential adder writes results back through an update port. It replaces the per-neuron, level-triggered decay blocks with one parametrised, synchronous unit.

---
 rtl/snn_decay_pkg.sv | 27 ++
 rtl/fp32_decay_core.sv | 55 +++++
 rtl/potential_decay_array.sv | 130 +++++++++++++
 tb/tb_potential_decay_array.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_decay_pkg.sv
// Shared constants for the LIF membrane-potential decay engine:
// rate codes, FSM states and FP32 field positions.
package snn_decay_pkg;

  localparam logic [3:0] DECAY_DIV1 = 4'b0001;
  localparam logic [3:0] DECAY_DIV2 = 4'b0010;
  localparam logic [3:0] DECAY_DIV4 = 4'b0100;
  localparam logic [3:0] DECAY_DIV8 = 4'b1000;
  localparam logic [3:0] DECAY_075  = 4'b0011;

  localparam int unsigned SignBit = 31;
  localparam int unsigned ExpMsb  = 30;
  localparam int unsigned ExpLsb  = 23;
  localparam int unsigned FracMsb = 22;
  localparam logic [7:0]  ExpMax  = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StFinish
  } state_e;

  function automatic logic [31:0] fp32_signed_zero(input logic sign);
    return {sign, 31'b0};
  endfunction

endpackage

// File: rtl/fp32_decay_core.sv
// Combinational FP32 decay: divide by 2^n or multiply by 0.75 with a single truncation.
// Zero/denormal inputs optionally flush to signed zero; Inf/NaN pass through.
module fp32_decay_core
  import snn_decay_pkg::*;
#(
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic [31:0] value,
  input  logic [3:0]  rate,
  output logic [31:0] result
);

  logic        sign;
  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic [25:0] prod;
  logic [7:0]  shift;

  always_comb begin
    sign   = value[SignBit];
    exp_f  = value[ExpMsb:ExpLsb];
    frac   = value[FracMsb:0];
    prod   = 26'({1'b1, frac}) * 26'd3;
    shift  = 8'd0;
    result = value;

    if (exp_f == 8'd0) begin
      if (FLUSH_DENORM) result = fp32_signed_zero(sign);
    end else if (exp_f != ExpMax) begin
      case (rate)
        DECAY_DIV1: shift = 8'd0;
        DECAY_DIV2: shift = 8'd1;
        DECAY_DIV4: shift = 8'd2;
        DECAY_DIV8: shift = 8'd3;
        DECAY_075: begin
          // 3*M lands in [3*2^23, 3*2^24): one or two bits above the hidden-one position.
          if (prod[25]) begin
            result = {sign, exp_f, prod[24:2]};
          end else if (exp_f == 8'd1) begin
            result = fp32_signed_zero(sign);
          end else begin
            result = {sign, exp_f - 8'd1, prod[23:1]};
          end
        end
        default: shift = 8'd0;
      endcase

      if (shift != 8'd0) begin
        if (exp_f <= shift) result = fp32_signed_zero(sign);
        else                result = {sign, exp_f - shift, frac};
      end
    end
  end

endmodule

// File: rtl/potential_decay_array.sv
// Multi-neuron membrane-potential store; each start pulse sweeps every neuron once,
// decaying it in place and streaming the result out, one neuron per cycle.
module potential_decay_array
  import snn_decay_pkg::*;
#(
  parameter int unsigned NUM_NEURONS  = 4,
  parameter int unsigned ADDR_W       = $clog2(NUM_NEURONS),
  parameter bit          FLUSH_DENORM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_valid,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_potential,
  input  logic [3:0]        init_rate,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [31:0]       upd_potential,
  output logic              cfg_ready,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_NEURONS - 1);

  logic [31:0]       pot_q  [NUM_NEURONS];
  logic [31:0]       pot_d  [NUM_NEURONS];
  logic [3:0]        rate_q [NUM_NEURONS];
  logic [3:0]        rate_d [NUM_NEURONS];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       out_pot_q, out_pot_d;
  logic              done_q, done_d;
  logic [31:0]       decayed;

  fp32_decay_core #(
    .FLUSH_DENORM(FLUSH_DENORM)
  ) u_core (
    .value (pot_q[idx_q]),
    .rate  (rate_q[idx_q]),
    .result(decayed)
  );

  always_comb begin
    pot_d       = pot_q;
    rate_d      = rate_q;
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;
    out_addr_d  = out_addr_q;
    out_pot_d   = out_pot_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A write coinciding with start lands before the sweep's first read.
        if (init_valid) begin
          pot_d[init_addr]  = init_potential;
          rate_d[init_addr] = init_rate;
        end else if (upd_valid) begin
          pot_d[upd_addr] = upd_potential;
        end
        if (start) begin
          idx_d   = '0;
          state_d = StSweep;
        end
      end
      StSweep: begin
        pot_d[idx_q] = decayed;
        busy_d       = 1'b1;
        out_valid_d  = 1'b1;
        out_addr_d   = idx_q;
        out_pot_d    = decayed;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StFinish;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_q[i]  <= 32'h0;
        rate_q[i] <= DECAY_DIV1;
      end
      state_q     <= StIdle;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_pot_q   <= 32'h0;
      done_q      <= 1'b0;
    end else begin
      pot_q       <= pot_d;
      rate_q      <= rate_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_pot_q   <= out_pot_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready     = (state_q == StIdle);
  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign out_addr      = out_addr_q;
  assign out_potential = out_pot_q;
  assign done          = done_q;

endmodule

// File: tb/tb_potential_decay_array.sv
// Self-checking bench for potential_decay_array: directed vectors, corner sequences and
// randomized sweeps compared against an arithmetic reference model.
module tb_potential_decay_array;

  localparam int N     = 4;
  localparam int AW    = 2;
  localparam bit FLUSH = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_valid;
  logic [AW-1:0] init_addr;
  logic [31:0]   init_potential;
  logic [3:0]    init_rate;
  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic [31:0]   upd_potential;
  logic          cfg_ready;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_potential;
  logic          done;

  always #5 clk = ~clk;

  potential_decay_array #(
    .NUM_NEURONS (N),
    .ADDR_W      (AW),
    .FLUSH_DENORM(FLUSH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .init_valid    (init_valid),
    .init_addr     (init_addr),
    .init_potential(init_potential),
    .init_rate     (init_rate),
    .upd_valid     (upd_valid),
    .upd_addr      (upd_addr),
    .upd_potential (upd_potential),
    .cfg_ready     (cfg_ready),
    .start         (start),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .out_potential (out_potential),
    .done          (done)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] mpot  [N];
  logic [3:0]  mrate [N];
  logic [31:0] last_out [N];

  typedef struct {
    logic [31:0] pot;
    logic [3:0]  rate;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Value-level reference: scale by 2^-n or 0.75, renormalise, truncate, flush underflow.
  function automatic logic [31:0] model_decay(input logic [31:0] v, input logic [3:0] r);
    logic   s;
    int     e;
    int     steps;
    longint m;
    s     = v[31];
    e     = int'(v[30:23]);
    m     = longint'({1'b1, v[22:0]});
    steps = 0;
    if (e == 0) return FLUSH ? {s, 31'b0} : v;
    if (e == 255) return v;
    case (r)
      4'b0010: steps = 1;
      4'b0100: steps = 2;
      4'b1000: steps = 3;
      4'b0011: begin
        m = m * 3;
        e = e - 2;
        while (m >= (64'd1 << 24)) begin
          m = m >> 1;
          e++;
        end
        if (e <= 0) return {s, 31'b0};
        return {s, 8'(e), m[22:0]};
      end
      default: return v;
    endcase
    e = e - steps;
    if (e <= 0) return {s, 31'b0};
    return {s, 8'(e), v[22:0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mpot[i]  = 32'h0;
      mrate[i] = 4'b0001;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic write_init(input logic [AW-1:0] a, input logic [31:0] p, input logic [3:0] r);
    init_valid     = 1'b1;
    init_addr      = a;
    init_potential = p;
    init_rate      = r;
    @(negedge clk);
    init_valid = 1'b0;
    mpot[a]    = p;
    mrate[a]   = r;
  endtask

  // One full sweep; optionally a write-back coinciding with start, and optionally
  // a write plus a second start issued while busy (both must be ignored).
  task automatic sweep(input bit upd_en, input logic [AW-1:0] ua, input logic [31:0] uv,
                       input bit late);
    logic [31:0] expv [N];
    if (upd_en) begin
      upd_valid     = 1'b1;
      upd_addr      = ua;
      upd_potential = uv;
      mpot[ua]      = uv;
    end
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    upd_valid = 1'b0;
    check("cfg_ready_low_sweep", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < N; i++) expv[i] = model_decay(mpot[i], mrate[i]);
    for (int i = 0; i < N; i++) begin
      if (late && i == 0) begin
        upd_valid     = 1'b1;
        upd_addr      = 2'd2;
        upd_potential = 32'h7F000000;
      end
      if (late && i == 1) start = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      start     = 1'b0;
      check("out_valid", 32'(out_valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("out_addr", 32'(out_addr), i);
      check("out_potential", out_potential, expv[i]);
      check("done_early", 32'(done), 32'd0);
      last_out[i] = out_potential;
    end
    for (int i = 0; i < N; i++) mpot[i] = expv[i];
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("out_valid_finish", 32'(out_valid), 32'd0);
    check("busy_finish", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    check("no_restart", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; init_valid = 1'b0; init_addr = '0; init_potential = '0; init_rate = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_potential = '0; start = 1'b0;
    model_clear();

    vecs[0] = '{pot: 32'h41DED852, rate: 4'b0010, expv: 32'h415ED852};
    vecs[1] = '{pot: 32'hC1DED852, rate: 4'b0010, expv: 32'hC15ED852};
    vecs[2] = '{pot: 32'h01800000, rate: 4'b1000, expv: 32'h00000000};
    vecs[3] = '{pot: 32'h7F800000, rate: 4'b0010, expv: 32'h7F800000};
    vecs[4] = '{pot: 32'h41DED852, rate: 4'b0011, expv: 32'h41A7223D};
    vecs[5] = '{pot: 32'h80400000, rate: 4'b0001, expv: 32'h80000000};
    vecs[6] = '{pot: 32'h40000000, rate: 4'b1111, expv: 32'h40000000};
    vecs[7] = '{pot: 32'h00800000, rate: 4'b0011, expv: 32'h00000000};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_potential", out_potential, 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    foreach (vecs[v]) begin
      do_reset();
      write_init(2'd0, vecs[v].pot, vecs[v].rate);
      sweep(1'b0, '0, '0, 1'b0);
      check($sformatf("table_%0d", v), last_out[0], vecs[v].expv);
    end

    // Repeated decay across two sweeps.
    do_reset();
    write_init(2'd0, 32'h41DED852, 4'b0010);
    sweep(1'b0, '0, '0, 1'b0);
    check("two_sweeps_1", last_out[0], 32'h415ED852);
    sweep(1'b0, '0, '0, 1'b0);
    check("two_sweeps_2", last_out[0], 32'h40DED852);

    // Four neurons, four rate codes.
    do_reset();
    write_init(2'd0, 32'h41DED852, 4'b0001);
    write_init(2'd1, 32'h41DED852, 4'b0100);
    write_init(2'd2, 32'h41DED852, 4'b1000);
    write_init(2'd3, 32'h41DED852, 4'b0011);
    sweep(1'b0, '0, '0, 1'b0);
    check("four_n0", last_out[0], 32'h41DED852);
    check("four_n1", last_out[1], 32'h40DED852);
    check("four_n2", last_out[2], 32'h405ED852);
    check("four_n3", last_out[3], 32'h41A7223D);

    // Init and update in the same cycle: init wins.
    init_valid = 1'b1; init_addr = 2'd3; init_potential = 32'h40800000; init_rate = 4'b0001;
    upd_valid  = 1'b1; upd_addr  = 2'd3; upd_potential  = 32'h12345678;
    @(negedge clk);
    init_valid = 1'b0; upd_valid = 1'b0;
    mpot[3] = 32'h40800000; mrate[3] = 4'b0001;
    sweep(1'b0, '0, '0, 1'b0);
    check("init_beats_upd", last_out[3], 32'h40800000);

    // Write-back coinciding with start; writes and start while busy are dropped.
    do_reset();
    write_init(2'd1, 32'h12345678, 4'b0010);
    sweep(1'b1, 2'd1, 32'h40000000, 1'b1);
    check("upd_with_start", last_out[1], 32'h3F800000);
    sweep(1'b0, '0, '0, 1'b0);
    check("busy_upd_dropped", last_out[2], 32'h00000000);

    // Reset during the second cycle of a sweep.
    do_reset();
    write_init(2'd0, 32'h41DED852, 4'b0010);
    write_init(2'd2, 32'h3F800000, 4'b0011);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_addr", 32'(out_addr), 32'd0);
    check("midrst_out_potential", out_potential, 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    for (int c = 0; c < N + 2; c++) begin
      check("midrst_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    sweep(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < N; i++) check("midrst_cleared", last_out[i], 32'h0);

    // Randomized inits and sweeps against the model.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        logic [31:0] p;
        logic [3:0]  r;
        p = $urandom;
        case ($urandom_range(0, 9))
          0: p[30:23] = 8'd0;
          1: p[30:23] = 8'd1;
          2: p[30:23] = 8'd2;
          3: p[30:23] = 8'hFF;
          default: ;
        endcase
        case ($urandom_range(0, 5))
          0: r = 4'b0001;
          1: r = 4'b0010;
          2: r = 4'b0100;
          3: r = 4'b1000;
          4: r = 4'b0011;
          default: r = 4'($urandom);
        endcase
        write_init(AW'($urandom_range(0, N - 1)), p, r);
      end
      sweep(1'b0, '0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
